// File: rtl/sm3_msg_expand.sv
// SM3 message expansion: loads a 512-bit block and streams W[s..s+3] / W'[s..s+3], four words per beat.
// Latency: first beat visible the cycle after start is accepted; one beat per accepted cycle, done one cycle after beat s=60.
// Backpressure: out_ready low freezes the window, step index and all beat outputs.
// Optional: define SM3_EXP_BYTE_SWAP_EN to byte-reverse each block_in word at load (little-endian buffers).
module sm3_msg_expand (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [511:0] block_in,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [6:0]   s,
  output logic [31:0]  wj_0,
  output logic [31:0]  wj_1,
  output logic [31:0]  wj_2,
  output logic [31:0]  wj_3,
  output logic [31:0]  fj_0,
  output logic [31:0]  fj_1,
  output logic [31:0]  fj_2,
  output logic [31:0]  fj_3,
  output logic         done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] win [16];
  logic [31:0] nw  [4];
  logic [31:0] ld  [16];
  logic [6:0]  s_q;
  logic        accept;
  logic        load;

  function automatic logic [31:0] rol(input logic [31:0] x, input int unsigned n);
    rol = (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    p1 = x ^ rol(x, 15) ^ rol(x, 23);
  endfunction

  assign load   = (state_q == ST_IDLE) && start;
  assign accept = (state_q == ST_STREAM) && out_ready;

  // Slice block_in into words; W0 lives in the top 32 bits.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
`ifdef SM3_EXP_BYTE_SWAP_EN
      ld[i] = {block_in[511-32*i-24 -: 8], block_in[511-32*i-16 -: 8],
               block_in[511-32*i-8  -: 8], block_in[511-32*i    -: 8]};
`else
      ld[i] = block_in[511-32*i -: 32];
`endif
    end
  end

  // Next four expanded words W[s+16..s+19]; the last one chains on the first.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      nw[i] = p1(win[i] ^ win[i+7] ^ rol(win[i+13], 15)) ^ rol(win[i+3], 7) ^ win[i+10];
    end
    nw[3] = p1(win[3] ^ win[10] ^ rol(nw[0], 15)) ^ rol(win[6], 7) ^ win[13];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next-state: load, stream 16 beats, single done cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_STREAM;
      ST_STREAM: if (accept && (s_q == 7'd60)) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Step index: 0 on load, +4 per accepted beat, parked at 64 otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q <= 7'd64;
    end else if (load) begin
      s_q <= 7'd0;
    end else if (accept) begin
      s_q <= (s_q == 7'd60) ? 7'd64 : s_q + 7'd4;
    end
  end

  // Window: load 16 words, or slide by four and append the new words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) win[i] <= ld[i];
    end else if (accept && (s_q != 7'd60)) begin
      for (int i = 0; i < 12; i++) win[i] <= win[i+4];
      for (int i = 0; i < 4; i++)  win[12+i] <= nw[i];
    end
  end

  assign out_valid = (state_q == ST_STREAM);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign s         = s_q;
  assign wj_0      = win[0];
  assign wj_1      = win[1];
  assign wj_2      = win[2];
  assign wj_3      = win[3];
  assign fj_0      = win[0] ^ win[4];
  assign fj_1      = win[1] ^ win[5];
  assign fj_2      = win[2] ^ win[6];
  assign fj_3      = win[3] ^ win[7];

endmodule

// File: tb/tb_sm3_msg_expand.sv
// Self-checking bench for sm3_msg_expand: directed sequence with random blocks/backpressure
// against a full W[0..67] reference expansion computed straight from the SM3 formula.
module tb_sm3_msg_expand;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [511:0] block_in = '0;
  logic         busy, out_valid, done;
  logic         out_ready = 1'b0;
  logic [6:0]   s;
  logic [31:0]  wj_0, wj_1, wj_2, wj_3, fj_0, fj_1, fj_2, fj_3;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] wm [68];

  always #5 clk = ~clk;

  sm3_msg_expand dut (
    .clk(clk), .rst(rst), .start(start), .block_in(block_in),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .s(s),
    .wj_0(wj_0), .wj_1(wj_1), .wj_2(wj_2), .wj_3(wj_3),
    .fj_0(fj_0), .fj_1(fj_1), .fj_2(fj_2), .fj_3(fj_3),
    .done(done)
  );

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference: whole expansion W[0..67] from the block.
  task automatic calc(input logic [511:0] blk);
    logic [31:0] x;
    for (int j = 0; j < 16; j++) begin
      x = blk[511-32*j -: 32];
`ifdef SM3_EXP_BYTE_SWAP_EN
      x = {x[7:0], x[15:8], x[23:16], x[31:24]};
`endif
      wm[j] = x;
    end
    for (int j = 16; j < 68; j++) begin
      x = wm[j-16] ^ wm[j-9] ^ rl(wm[j-3], 15);
      wm[j] = (x ^ rl(x, 15) ^ rl(x, 23)) ^ rl(wm[j-13], 7) ^ wm[j-6];
    end
  endtask

  function automatic logic [511:0] rnd_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // Called at posedge+1 with DUT in IDLE. mode: 0 ready high, 1 toggling, 2 random.
  task automatic run_block(input logic [511:0] blk, input int mode, input int inj,
                           input int rst_at, input bit is_abc, input bit btb,
                           input logic [511:0] nxt);
    int beat, cyc, b4;
    bit tog, rdy;
    start = 1'b1;
    block_in = blk;
    @(posedge clk); #1;
    start = 1'b0;
    block_in = rnd_block();
    calc(blk);
    beat = 0; cyc = 1; tog = 1'b1;
    while (beat < 16 && cyc < 200) begin
      b4 = 4 * beat;
      chk("out_valid", {31'b0, out_valid}, 32'd1);
      chk("busy", {31'b0, busy}, 32'd1);
      chk("done_low", {31'b0, done}, 32'd0);
      chk("s", {25'b0, s}, b4);
      chk("wj_0", wj_0, wm[b4]);
      chk("wj_1", wj_1, wm[b4+1]);
      chk("wj_2", wj_2, wm[b4+2]);
      chk("wj_3", wj_3, wm[b4+3]);
      chk("fj_0", fj_0, wm[b4] ^ wm[b4+4]);
      chk("fj_1", fj_1, wm[b4+1] ^ wm[b4+5]);
      chk("fj_2", fj_2, wm[b4+2] ^ wm[b4+6]);
      chk("fj_3", fj_3, wm[b4+3] ^ wm[b4+7]);
      if (is_abc && beat == 0) begin
        chk("abc_wj0_s0", wj_0, 32'h61626380);
        chk("abc_fj0_s0", fj_0, 32'h61626380);
      end
      if (is_abc && beat == 4) begin
        chk("abc_wj0_s16", wj_0, 32'h9092e200);
        chk("abc_wj1_s16", wj_1, 32'h00000000);
        chk("abc_wj2_s16", wj_2, 32'h000c0606);
        chk("abc_wj3_s16", wj_3, 32'h719c70ed);
      end
      if (rst_at == beat) begin
        rst = 1'b0;
        #1;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_s", {25'b0, s}, 32'd64);
        chk("rst_wj0", wj_0, 32'd0);
        chk("rst_fj3", fj_3, 32'd0);
        #2;
        rst = 1'b1;
        out_ready = 1'b0;
        return;
      end
      if (inj == beat) begin
        start = 1'b1;
        block_in = rnd_block();
      end else begin
        start = 1'b0;
      end
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(1));
      tog = ~tog;
      out_ready = rdy;
      @(posedge clk); #1;
      cyc++;
      if (rdy) beat++;
    end
    start = 1'b0;
    chk("beats_accepted", beat, 32'd16);
    if (mode == 0) chk("done_latency", cyc, 32'd17);
    chk("done_pulse", {31'b0, done}, 32'd1);
    chk("done_valid", {31'b0, out_valid}, 32'd0);
    chk("done_s", {25'b0, s}, 32'd64);
    chk("done_busy", {31'b0, busy}, 32'd1);
    if (btb) begin
      start = 1'b1;
      block_in = nxt;
    end
    @(posedge clk); #1;
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_done", {31'b0, done}, 32'd0);
    chk("idle_valid", {31'b0, out_valid}, 32'd0);
  endtask

  logic [511:0] abc, b1, b2;

  initial begin
`ifdef SM3_EXP_BYTE_SWAP_EN
    abc = {32'h80636261, 448'h0, 32'h18000000};
`else
    abc = {32'h61626380, 448'h0, 32'h00000018};
`endif
    // Reset state.
    #12;
    chk("reset_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_s", {25'b0, s}, 32'd64);
    chk("reset_wj0", wj_0, 32'd0);
    chk("reset_fj0", fj_0, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // "abc" block, ready held high, then toggling.
    run_block(abc, 0, -1, -1, 1'b1, 1'b0, '0);
    run_block(abc, 1, -1, -1, 1'b1, 1'b0, '0);

    // Start during streaming at s=24 is ignored.
    run_block(rnd_block(), 2, 6, -1, 1'b0, 1'b0, '0);

    // Reset mid-block at s=32, then a fresh block.
    run_block(rnd_block(), 0, -1, 8, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    run_block(rnd_block(), 0, -1, -1, 1'b0, 1'b0, '0);

    // Back-to-back: start raised in DONE (ignored), held into IDLE (accepted).
    b1 = rnd_block();
    b2 = rnd_block();
    run_block(b1, 0, -1, -1, 1'b0, 1'b1, b2);
    run_block(b2, 2, -1, -1, 1'b0, 1'b0, '0);

    // A few more random blocks under random backpressure.
    for (int n = 0; n < 3; n++) run_block(rnd_block(), 2, -1, -1, 1'b0, 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
